// File: rtl/board_pkg.sv
// Shared board-level types and constants for the main-CPU to sound command path.
// The sound command transmitter uses the state type, default sizes and status packing below.
package board_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      HOLD     = 2'd2,
      WAIT_ACK = 2'd3
   } snd_tx_state_t;

   localparam int SND_CMD_DEPTH   = 4;
   localparam int SND_CMD_TIMEOUT = 400000;

   // Bit layout of the status byte the CPU reads back.
   function automatic logic [7:0] snd_status_pack(
      input logic       overflow,
      input logic       timeout,
      input logic       active,
      input logic       full,
      input logic       empty,
      input logic [2:0] count
   );
      snd_status_pack = {overflow, timeout, active, full, empty, count};
   endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Small synchronous register FIFO holding sound command bytes.
// A push while full is dropped, judged on the count before any same-cycle pop.
import board_pkg::*;

module sound_cmd_fifo #(
   parameter int DEPTH = SND_CMD_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [2:0] count,
   output logic       full,
   output logic       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == 3'(DEPTH));
   assign empty   = (count == 3'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage needs no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + 3'(do_push) - 3'(do_pop);
      end
   end

endmodule

// File: rtl/sound_cmd_tx.sv
// Queues main-CPU sound command bytes and hands them to the sound latch one per Z80 ack.
// Optional WAIT_ACK timeout is compiled in with the SND_CMD_TIMEOUT_EN macro.
import board_pkg::*;

module sound_cmd_tx #(
   parameter int DEPTH          = SND_CMD_DEPTH,
   parameter int TIMEOUT_CYCLES = SND_CMD_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       paused,
   input  logic       cpu_wr,
   input  logic [7:0] cpu_din,
   input  logic       status_rd,
   output logic [7:0] status,
   output logic       latch_wr,
   output logic [7:0] latch_dout,
   input  logic       latch_busy
);

   if (!(DEPTH == 2 || DEPTH == 4) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("sound_cmd_tx: DEPTH must be 2 or 4 and TIMEOUT_CYCLES at least 2");
   end

   snd_tx_state_t state;
   snd_tx_state_t state_next;

   logic [7:0] fifo_dout;
   logic [2:0] fifo_count;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   logic       overflow;
   logic       timeout_flag;
   logic       timeout_hit;

   sound_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cpu_wr),
      .pop   (pop),
      .din   (cpu_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef SND_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] to_cnt;

   assign timeout_hit = (state == WAIT_ACK) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Counts unpaused WAIT_ACK cycles; any other state restarts it from zero.
   always_ff @(posedge clk) begin
      if (reset || state != WAIT_ACK) begin
         to_cnt <= '0;
      end else if (!paused) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_flag <= 1'b0;
      end else begin
         timeout_flag <= (timeout_hit & ~paused & latch_busy) | (timeout_flag & ~status_rd);
      end
   end
`else
   assign timeout_hit  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         latch_dout <= 8'h00;
         overflow   <= 1'b0;
      end else begin
         state <= state_next;
         if (pop) begin
            latch_dout <= fifo_dout;
         end
         overflow <= (cpu_wr & fifo_full) | (overflow & ~status_rd);
      end
   end

   // SEND is only entered unpaused because the sound block ignores latch_wr while paused;
   // HOLD gives the sound block a cycle to raise latch_busy before it is trusted.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      latch_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !paused && !latch_busy) begin
               pop        = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            latch_wr   = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (!paused && (!latch_busy || timeout_hit)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign status = snd_status_pack(overflow, timeout_flag, state != IDLE,
                                   fifo_full, fifo_empty, fifo_count);

endmodule
